smol_axis_sink: RTL and testbench

- Consumer end of the 32-bit AXI-Stream valid/ready link; the counterpart to the stream producer side.
- Accepts words through a vld/rdy handshake into a small first-word-fall-through FIFO.
- Presents buffered words to a downstream core through a simple pop interface.
- Keeps a word count and a wrap-around checksum, and flags producer protocol violations for bring-up.

---
 rtl/smol_axis_sink.sv | 118 +++++++++++
 tb/tb_smol_axis_sink.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/smol_axis_sink.sv
// Purpose: consumer end of a 32-bit valid/ready stream: small FWFT FIFO, word statistics, producer protocol check.
// Latency: a word accepted on edge N is on pop_data/pop_vld from cycle N+1; pop takes effect on the same edge.
// Backpressure: s_rdy comes from registers only; it drops when the FIFO is full or one cycle after hold is sampled high.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   s_data/s_vld/s_rdy stream input from the producer
//   hold              downstream throttle, registered once before it gates s_rdy
//   clr               synchronous flush of FIFO, statistics and error flag (wins over push/pop)
//   pop/pop_data/pop_vld  downstream consume interface, head word shown first-word-fall-through
//   level             FIFO occupancy
//   word_cnt/checksum accepted-word count and wrap-around sum
//   proto_err         sticky producer protocol violation flag
module smol_axis_sink #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_vld,
    output logic              s_rdy,
    input  logic              hold,
    input  logic              clr,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_vld,
    output logic [LW-1:0]     level,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [DATA_W-1:0] checksum,
    output logic              proto_err
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              hold_q;
    // Cleared by reset, set on the first edge after release: keeps s_rdy low
    // while reset is asserted even though level and hold_q are zero then.
    logic              run_q;
    logic              stalled;
    logic [DATA_W-1:0] stall_data;

    logic do_push;
    logic do_pop;

    assign s_rdy    = run_q && (level != FULL_LVL) && !hold_q;
    assign pop_vld  = (level != '0);
    assign pop_data = mem[rd_ptr];

    assign do_push = s_vld && s_rdy && !clr;
    assign do_pop  = pop && pop_vld && !clr;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            word_cnt   <= '0;
            checksum   <= '0;
            proto_err  <= 1'b0;
            hold_q     <= 1'b0;
            run_q      <= 1'b0;
            stalled    <= 1'b0;
            stall_data <= '0;
        end else begin
            run_q  <= 1'b1;
            hold_q <= hold;
            if (clr) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                level     <= '0;
                word_cnt  <= '0;
                checksum  <= '0;
                proto_err <= 1'b0;
                stalled   <= 1'b0;
            end else begin
                if (do_push) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    word_cnt <= word_cnt + CNT_W'(1);
                    checksum <= checksum + s_data;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase

                // A stalled producer must hold valid and data until accepted.
                if (stalled && (!s_vld || (s_data != stall_data))) begin
                    proto_err <= 1'b1;
                end
                // The stall ends on handshake (or on the valid drop just flagged).
                stalled <= s_vld && !s_rdy;
                // Latch the word offered on the first stalled cycle only.
                if (s_vld && !s_rdy && !stalled) begin
                    stall_data <= s_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_smol_axis_sink.sv
module tb_smol_axis_sink;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_vld;
    logic        s_rdy;
    logic        hold;
    logic        clr;
    logic        pop;
    logic [31:0] pop_data;
    logic        pop_vld;
    logic [2:0]  level;
    logic [15:0] word_cnt;
    logic [31:0] checksum;
    logic        proto_err;

    int n_chk;
    int n_fail;

    smol_axis_sink #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_vld     (s_vld),
        .s_rdy     (s_rdy),
        .hold      (hold),
        .clr       (clr),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_vld   (pop_vld),
        .level     (level),
        .word_cnt  (word_cnt),
        .checksum  (checksum),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and wait (bounded) for it to be accepted.
    task automatic push(input logic [31:0] d);
        int n;
        s_vld  = 1'b1;
        s_data = d;
        n = 0;
        while (!s_rdy && n < 50) begin
            tick();
            n++;
        end
        chk("push_rdy", {31'd0, s_rdy}, 32'd1);
        tick();
        s_vld = 1'b0;
    endtask

    task automatic pop_chk(input logic [31:0] exp);
        chk("pop_vld", {31'd0, pop_vld}, 32'd1);
        chk("pop_data", pop_data, exp);
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        s_data = '0;
        s_vld  = 1'b0;
        hold   = 1'b0;
        clr    = 1'b0;
        pop    = 1'b0;

        // Reset state
        #12;
        chk("rst_s_rdy",     {31'd0, s_rdy}, 32'd0);
        chk("rst_pop_vld",   {31'd0, pop_vld}, 32'd0);
        chk("rst_level",     {29'd0, level}, 32'd0);
        chk("rst_word_cnt",  {16'd0, word_cnt}, 32'd0);
        chk("rst_checksum",  checksum, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        #10 rst_n = 1'b1;
        tick();
        chk("rel_s_rdy", {31'd0, s_rdy}, 32'd1);

        // Basic flow
        s_vld = 1'b1; s_data = 32'h11;
        tick();
        chk("b_pop_vld",  {31'd0, pop_vld}, 32'd1);
        chk("b_pop_data", pop_data, 32'h11);
        chk("b_level1",   {29'd0, level}, 32'd1);
        s_data = 32'h22;
        tick();
        chk("b_s_rdy", {31'd0, s_rdy}, 32'd1);
        s_data = 32'h33;
        tick();
        s_vld = 1'b0;
        chk("b_level3",   {29'd0, level}, 32'd3);
        chk("b_word_cnt", {16'd0, word_cnt}, 32'd3);
        chk("b_checksum", checksum, 32'h66);
        chk("b_s_rdy3",   {31'd0, s_rdy}, 32'd1);
        pop_chk(32'h11);
        pop_chk(32'h22);
        pop_chk(32'h33);
        chk("b_level0", {29'd0, level}, 32'd0);

        // Full and backpressure
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        chk("f_s_rdy_full", {31'd0, s_rdy}, 32'd0);
        chk("f_level_full", {29'd0, level}, 32'd4);
        s_vld = 1'b1; s_data = 32'hA4;
        tick();
        tick();
        chk("f_s_rdy_held", {31'd0, s_rdy}, 32'd0);
        chk("f_level_held", {29'd0, level}, 32'd4);
        chk("f_proto_ok",   {31'd0, proto_err}, 32'd0);
        chk("f_head", pop_data, 32'hA0);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("f_s_rdy_freed", {31'd0, s_rdy}, 32'd1);
        chk("f_level3",      {29'd0, level}, 32'd3);
        tick();
        s_vld = 1'b0;
        chk("f_level_a4", {29'd0, level}, 32'd4);
        pop_chk(32'hA1);
        pop_chk(32'hA2);
        pop_chk(32'hA3);
        pop_chk(32'hA4);
        chk("f_word_cnt", {16'd0, word_cnt}, 32'd8);
        chk("f_checksum", checksum, 32'h390);
        chk("f_proto_end", {31'd0, proto_err}, 32'd0);

        // Checksum wrap after a clear
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("c_clr_cnt", {16'd0, word_cnt}, 32'd0);
        chk("c_clr_sum", checksum, 32'd0);
        push(32'hFFFF_FFFF);
        push(32'h0000_0002);
        chk("c_wrap_sum", checksum, 32'h1);
        chk("c_wrap_cnt", {16'd0, word_cnt}, 32'd2);
        pop_chk(32'hFFFF_FFFF);
        pop_chk(32'h0000_0002);

        // Stream through with pop tied high, across pointer wrap
        pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_vld = 1'b1; s_data = 32'h100 + 32'(i);
            tick();
            chk("s_level", {29'd0, level}, 32'd1);
            chk("s_data",  pop_data, 32'h100 + 32'(i));
        end
        s_vld = 1'b0;
        tick();
        pop = 1'b0;
        chk("s_level_end", {29'd0, level}, 32'd0);
        chk("s_checksum",  checksum, 32'hA2E);
        chk("s_word_cnt",  {16'd0, word_cnt}, 32'd12);

        // Simultaneous push and pop at level 2, then pop while empty
        push(32'h51);
        push(32'h52);
        s_vld = 1'b1; s_data = 32'h53; pop = 1'b1;
        tick();
        s_vld = 1'b0; pop = 1'b0;
        chk("sp_level", {29'd0, level}, 32'd2);
        chk("sp_head",  pop_data, 32'h52);
        pop_chk(32'h52);
        pop_chk(32'h53);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("e_level",     {29'd0, level}, 32'd0);
        chk("e_pop_vld",   {31'd0, pop_vld}, 32'd0);
        chk("e_proto_err", {31'd0, proto_err}, 32'd0);
        push(32'h54);
        pop_chk(32'h54);

        // Protocol violation: data change while stalled
        hold = 1'b1;
        tick();
        chk("p_s_rdy_hold", {31'd0, s_rdy}, 32'd0);
        s_vld = 1'b1; s_data = 32'hAA;
        tick();
        chk("p_no_err_yet", {31'd0, proto_err}, 32'd0);
        s_data = 32'hAB;
        tick();
        chk("p_err_data", {31'd0, proto_err}, 32'd1);
        s_vld = 1'b0;
        tick();
        hold = 1'b0;
        tick();
        chk("p_err_sticky", {31'd0, proto_err}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("p_clr_err",   {31'd0, proto_err}, 32'd0);
        chk("p_clr_level", {29'd0, level}, 32'd0);
        chk("p_clr_cnt",   {16'd0, word_cnt}, 32'd0);
        chk("p_clr_sum",   checksum, 32'd0);

        // Protocol violation: valid dropped while stalled
        hold = 1'b1;
        tick();
        s_vld = 1'b1; s_data = 32'hCC;
        tick();
        s_vld = 1'b0;
        tick();
        chk("p_err_vld", {31'd0, proto_err}, 32'd1);
        hold = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("p_clr_err2", {31'd0, proto_err}, 32'd0);

        // Asynchronous reset mid-operation
        push(32'h61);
        push(32'h62);
        push(32'h63);
        chk("r_level3", {29'd0, level}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("r_s_rdy",    {31'd0, s_rdy}, 32'd0);
        chk("r_pop_vld",  {31'd0, pop_vld}, 32'd0);
        chk("r_level",    {29'd0, level}, 32'd0);
        chk("r_word_cnt", {16'd0, word_cnt}, 32'd0);
        chk("r_checksum", checksum, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("r_rel_s_rdy", {31'd0, s_rdy}, 32'd1);
        push(32'h77);
        chk("r_level1",   {29'd0, level}, 32'd1);
        chk("r_cnt1",     {16'd0, word_cnt}, 32'd1);
        pop_chk(32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
